// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: output-port arbiter for the mesh router.
// Picks among requesting input ports by priority class, round-robin within a
// class with the last-served port as lowest priority, and holds the grant
// for a whole packet. A packet releases on its TAIL flit, on a beat timeout
// loaded from the header length field, or when its request drops. Hand-over
// to the next requester happens without an idle bubble.
module noc_rr_arbiter #(
  parameter int          NPORTS  = 5,
  parameter int          PRIO_W  = 2,
  parameter int          LEN_W   = 12,
  parameter logic [2:0]  HEAD_ID = 3'b001,
  parameter logic [2:0]  TAIL_ID = 3'b100,
  localparam int         IDX_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*PRIO_W-1:0]  prio,
  input  logic [NPORTS*3-1:0]       flit_id,
  input  logic [NPORTS*LEN_W-1:0]   length,
  output logic [NPORTS-1:0]         grant,
  output logic                      idle,
  output logic [IDX_W-1:0]          last_served
);

  // Index of the currently granted port; meaningful only while busy.
  logic [IDX_W-1:0] cur;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  logic             busy;
  logic             req_p;
  logic [2:0]       fid_p;
  logic [LEN_W-1:0] len_p;
  logic             hdr_p;
  logic             rel;
  logic             arb;

  logic [PRIO_W-1:0] max_prio;
  logic              any_req;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;

  assign busy = |grant;

  // Decode the granted port's flit and decide whether its packet ends this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block
    // leaves it unassigned, which would infer a latch.
    req_p = req[cur];
    fid_p = flit_id[int'(cur)*3 +: 3];
    len_p = length[int'(cur)*LEN_W +: LEN_W];
    hdr_p = req_p && (fid_p == HEAD_ID);
    rel   = 1'b0;
    if (busy) begin
      rel = !req_p
         || (fid_p == TAIL_ID)
         || ((len_q != '0) && ((cnt + LEN_W'(1)) == len_q))
         || (hdr_p && (len_p == LEN_W'(1)));
    end
    arb = !busy || rel;
  end

  // Pick the winner: highest class among requesters, then round-robin from
  // the port after last_served so the last-served port comes last.
  always_comb begin
    logic [IDX_W-1:0]  sel;
    logic [PRIO_W-1:0] p_sel;
    int                idx;
    max_prio  = '0;
    any_req   = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    sel       = '0;
    p_sel     = '0;
    idx       = 0;
    for (int i = 0; i < NPORTS; i++) begin
      sel   = IDX_W'(i);
      p_sel = prio[i*PRIO_W +: PRIO_W];
      if (req[sel] && (!any_req || (p_sel > max_prio))) begin
        max_prio = p_sel;
        any_req  = 1'b1;
      end
    end
    for (int k = 1; k <= NPORTS; k++) begin
      idx = int'(last_served) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      sel   = IDX_W'(idx);
      p_sel = prio[idx*PRIO_W +: PRIO_W];
      if (!win_found && req[sel] && (p_sel == max_prio)) begin
        win_found = 1'b1;
        win_idx   = sel;
      end
    end
  end

  // Grant register, packet beat counter and captured length.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      grant       <= '0;
      idle        <= 1'b1;
      last_served <= IDX_W'(NPORTS - 1);
      cur         <= '0;
      cnt         <= '0;
      len_q       <= '0;
    end else if (arb) begin
      if (win_found) begin
        grant       <= NPORTS'(1) << win_idx;
        idle        <= 1'b0;
        last_served <= win_idx;
        cur         <= win_idx;
        cnt         <= '0;
        len_q       <= '0;
      end else begin
        grant <= '0;
        idle  <= 1'b1;
      end
    end else begin
      // Holding the packet: count beats (saturating) and capture the header length.
      if (req_p && (cnt != '1)) cnt <= cnt + LEN_W'(1);
      if (hdr_p) len_q <= len_p;
    end
  end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed testbench for noc_rr_arbiter: round-robin order, header-length
// timeout, priority classes, request drop, tail hand-over and mid-packet reset.
module tb_noc_rr_arbiter;
  localparam int N  = 5;
  localparam int PW = 2;
  localparam int LW = 12;
  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*PW-1:0] prio;
  logic [N*3-1:0]  flit_id;
  logic [N*LW-1:0] length;
  logic [N-1:0]    grant;
  logic            idle;
  logic [2:0]      last_served;

  int n_cmp = 0;
  int n_err = 0;

  noc_rr_arbiter #(.NPORTS(N), .PRIO_W(PW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .prio(prio), .flit_id(flit_id),
    .length(length), .grant(grant), .idle(idle), .last_served(last_served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [N-1:0] g, input logic [2:0] ls);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".idle"}, 32'(idle), 32'(g == '0));
    check({tag, ".last"}, 32'(last_served), 32'(ls));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fid(input int p, input logic [2:0] f);
    flit_id[p*3 +: 3] = f;
  endtask

  task automatic set_len(input int p, input logic [LW-1:0] v);
    length[p*LW +: LW] = v;
  endtask

  task automatic set_prio(input int p, input logic [PW-1:0] v);
    prio[p*PW +: PW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; prio = '0; flit_id = '0; length = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int order [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    // Reset state and round-robin over all five ports, 2-beat packets.
    do_reset();
    check_state("reset", 5'b00000, 3'd4);
    req = '1;
    flit_id = {N{HEAD}};
    tick();
    for (int k = 0; k < 6; k++) begin
      check_state($sformatf("rr%0d.head", k), 5'(1) << order[k], 3'(order[k]));
      tick();
      check_state($sformatf("rr%0d.tail", k), 5'(1) << order[k], 3'(order[k]));
      flit_id = {N{TAIL}};
      tick();
      flit_id = {N{HEAD}};
    end

    // Port 2 alone, header length 4: four beats, then re-granted without a bubble.
    do_reset();
    req = 5'b00100; set_fid(2, HEAD); set_len(2, 12'd4);
    tick();
    check_state("len4.c1", 5'b00100, 3'd2);
    tick();
    set_fid(2, BODY);
    check_state("len4.c2", 5'b00100, 3'd2);
    tick();
    check_state("len4.c3", 5'b00100, 3'd2);
    tick();
    check_state("len4.c4", 5'b00100, 3'd2);
    tick();
    check_state("len4.c5", 5'b00100, 3'd2);
    tick(); tick(); tick();
    check_state("len4.hold", 5'b00100, 3'd2);

    // Same packet, but port 0 waits: the timeout hands over to port 0 in cycle 5.
    do_reset();
    req = 5'b00100; set_fid(2, HEAD); set_len(2, 12'd4);
    tick();
    tick();
    set_fid(2, BODY);
    req = 5'b00101;
    tick();
    check_state("tmo.c3", 5'b00100, 3'd2);
    tick();
    check_state("tmo.c4", 5'b00100, 3'd2);
    tick();
    check_state("tmo.c5", 5'b00001, 3'd0);

    // Priority: port 3 (class 2) beats port 1 (class 1); port 1 follows the tail.
    do_reset();
    req = 5'b00001; set_fid(0, HEAD); set_len(0, 12'd1);
    tick();
    check_state("prio.p0", 5'b00001, 3'd0);
    req = 5'b01010; set_prio(1, 2'd1); set_prio(3, 2'd2); set_fid(3, HEAD);
    tick();
    check_state("prio.p3", 5'b01000, 3'd3);
    tick();
    check_state("prio.p3hold", 5'b01000, 3'd3);
    set_fid(3, TAIL); set_prio(3, 2'd0);
    tick();
    check_state("prio.p1", 5'b00010, 3'd1);

    // Request drop on port 0 hands over to waiting port 4; then release to idle.
    do_reset();
    req = 5'b00001; set_fid(0, HEAD);
    tick();
    check_state("drop.p0", 5'b00001, 3'd0);
    req = 5'b10001;
    tick();
    check_state("drop.nopreempt", 5'b00001, 3'd0);
    req = 5'b10000;
    tick();
    check_state("drop.p4", 5'b10000, 3'd4);
    req = 5'b00000;
    tick();
    check_state("drop.idle", 5'b00000, 3'd4);

    // Tail on port 1 with ports 1 and 2 requesting: port 2 goes next.
    do_reset();
    req = 5'b00110; flit_id = {N{HEAD}};
    tick();
    check_state("tail.p1", 5'b00010, 3'd1);
    tick();
    set_fid(1, TAIL);
    tick();
    check_state("tail.p2", 5'b00100, 3'd2);

    // Reset in the middle of a packet on port 3.
    do_reset();
    req = 5'b01000; flit_id = {N{HEAD}};
    tick();
    check_state("rst.busy", 5'b01000, 3'd3);
    rst = 1'b1;
    tick();
    check_state("rst.mid", 5'b00000, 3'd4);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Parametrised output-port arbiter for the mesh router, one instance per output port. It arbitrates NPORTS input-port requests by priority class, with round-robin inside a class and the last-served port as least priority. A grant is held for the whole packet. Release happens on the TAIL flit, on a per-packet beat timeout loaded from the header length field, or when the request drops. This block generalises the fixed 5-port L/N/E/S/W arbiter: it adds N-port width, priority classes, zero-bubble hand-over and a registered one-hot grant.

## Interface
Parameters:
- NPORTS, 5, number of requesting input ports; index 0 is Local, then N, E, S, W.
- PRIO_W, 2, width of per-port priority class; a larger value is more urgent.
- LEN_W, 12, packet length field width in flits.
- HEAD_ID, 3'b001, flit_id code of a HEADER flit.
- TAIL_ID, 3'b100, flit_id code of a TAIL flit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NPORTS  request per input port.
- prio  in  NPORTS*PRIO_W  priority class; port i uses bits [i*PRIO_W +: PRIO_W].
- flit_id  in  NPORTS*3  flit type presented by each port.
- length  in  NPORTS*LEN_W  packet length; valid only with HEAD_ID.
- grant  out  NPORTS  registered one-hot grant; all zero when idle.
- idle  out  1  registered; 1 when no grant is active. Always equals ~|grant.
- last_served  out  clog2(NPORTS)  registered index of the most recently granted port.

## Operation
- State: IDLE (grant==0) or BUSY(p) (grant[p]==1). grant is always one-hot or zero.
- Reset: grant=0, idle=1, last_served=NPORTS-1, so port 0 has first round-robin priority. Beat counter and captured length are cleared to 0.
- Beat counter cnt (LEN_W bits):
  - cleared on every new grant;
  - increments each cycle that grant[p]&req[p];
  - saturates at all ones.
- Captured length len_q:
  - cleared on every new grant;
  - loaded from length[p] in any granted cycle where flit_id[p]==HEAD_ID.
  - len_q==0 disables the timeout.
- Release in BUSY(p) this cycle if any of the following holds:
  - req[p]==0;
  - req[p] and flit_id[p]==TAIL_ID (the tail beat is still granted this cycle);
  - len_q!=0 and cnt+1==len_q (the len_q-th beat is the last);
  - the same-cycle header load sets length[p]==1.
- Arbitration runs when IDLE or on a release cycle:
  - Eligible ports are all i with req[i]==1. The released port p is eligible only if req[p] is still 1 after a TAIL or timeout release.
  - Pick the maximum prio among eligible ports.
  - Among ports in that class, pick the first scanning from last_served+1 upward, modulo NPORTS.
  - If nothing is eligible, go to IDLE.
- On each new grant, last_served is updated to the granted index. A held grant does not change last_served.
- prio is sampled only at arbitration. Changing prio of the granted port mid-packet has no effect.
- Preemption is not supported. A higher class waits for the current packet to release.
- A single request with no TAIL flit and no header (len_q==0) holds indefinitely while req stays high.

## Timing
- Arbitration is combinational from req/prio/flit_id/length, grant and last_served. The result is registered.
- Request-to-grant latency: req[i] high in cycle t while IDLE gives grant[i]=1 in cycle t+1.
- Zero-bubble hand-over: TAIL, timeout or drop in cycle t with another eligible requester gives the new grant in t+1. The old port and the new port are never both granted.
- Release with no other requester: grant=0 and idle=1 in t+1.
- Drop of req[p] in cycle t: that cycle is not counted as a beat, and grant[p]=0 from t+1.
- Reset has priority over everything. Asserting rst mid-packet gives grant=0 in the next cycle; the packet state is discarded.

## Test plan
- Reset, then req=5'b11111 with equal prio: grant order 0,1,2,3,4,0. Each grant lasts one packet when TAIL_ID is presented 1 cycle after the header.
- Port 2 alone sends HEAD with length=4 and no tail: grant[2] is high for exactly 4 cycles. With req[2] still high afterwards, port 2 is re-granted in cycle 5 with no bubble.
- Ports 1 and 3 request, port 3 at prio=2 and port 1 at prio=1, last_served=0: port 3 is granted first. Port 1 is granted the cycle after port 3's TAIL.
- Port 0 granted with req[0] dropping mid-packet while port 4 requests: grant moves to port 4 the next cycle and last_served becomes 4.
- TAIL on port 1 while ports 1 and 2 request at equal prio: the next grant goes to port 2 (last served is least priority).
- rst asserted during BUSY(3): the next cycle gives grant=0, idle=1, last_served=NPORTS-1.
